alu_rr_sched: RTL

Round-robin scheduler that shares one 8-bit ALU datapath (ADD/SUB/AND/OR/NOT) between two requesters. Each requester presents an opcode and operands over a valid/ready handshake. The scheduler grants one requester, latches its operation, evaluates it in a single registered ALU stage, and returns the result with the requester id on a valid/ready response port. It sits between the instruction-issue logic and the shared arithmetic unit, and replaces direct per-client ALU instances.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 26 ++
 rtl/alu_rr_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_NOT = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic op_defined(input logic [3:0] op);
        return (op <= ALU_NOT);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU shared by both requesters; undefined opcodes yield zero with err set.
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);
    import alu_pkg::*;

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_NOT: y = ~a;
            default: err = !op_defined(op);
        endcase
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Two-requester round-robin front end for one shared ALU: arbitrate, latch, execute, respond.
module alu_rr_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    import alu_pkg::*;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               grant0, grant1;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_err;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .y   (alu_y),
        .err (alu_err)
    );

    // Under contention the requester that did not win last time gets the grant.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant_q);
        grant1     = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = (state_q == IDLE) && grant0;
        req1_ready = (state_q == IDLE) && grant1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;

        case (state_q)
            IDLE: begin
                if (req0_ready && req0_valid) begin
                    op_d         = req0_op;
                    a_d          = req0_a;
                    b_d          = req0_b;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (req1_ready && req1_valid) begin
                    op_d         = req1_op;
                    a_d          = req1_a;
                    b_d          = req1_b;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_y;
                rsp_err_d   = alu_err;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    // Operand latches are only consumed after an acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
        id_q <= id_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule
